// File: rtl/instr_sequencer.sv
// Fetch/decode/dispatch controller: latches an instruction, starts exactly one
// execution unit, waits for its done (bounded by a timeout) and then retires it.
module instr_sequencer #(
  parameter int unsigned NUM_UNITS = 4,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run_i,
  input  logic [15:0]          mem_rdata_i,
  input  logic                 mem_valid_i,
  input  logic [NUM_UNITS-1:0] unit_done_i,
  output logic [15:0]          ir_o,
  output logic [NUM_UNITS-1:0] unit_start_o,
  output logic                 pc_inc_o,
  output logic                 busy_o,
  output logic                 halted_o,
  output logic                 illegal_o,
  output logic                 timeout_err_o,
  output logic [15:0]          instr_count_o
);

  localparam int unsigned SelW   = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam int unsigned TimerW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StDispatch,
    StWait,
    StRetire,
    StHalted,
    StError
  } state_e;

  state_e               state_q, state_d;
  logic [15:0]          ir_q, ir_d;
  logic [SelW-1:0]      sel_q, sel_d;
  logic [TimerW-1:0]    timer_q, timer_d;
  logic [NUM_UNITS-1:0] unit_start_q, unit_start_d;
  logic                 pc_inc_q, pc_inc_d;
  logic                 busy_q, busy_d;
  logic                 halted_q, halted_d;
  logic                 illegal_q, illegal_d;
  logic                 timeout_q, timeout_d;
  logic [15:0]          instr_count_q, instr_count_d;

  logic                 dec_nop, dec_halt, dec_unit_vld;
  logic [1:0]           dec_unit;
  logic                 unit_ok;

  // Opcode decode of the latched instruction.
  always_comb begin
    dec_nop      = 1'b0;
    dec_halt     = 1'b0;
    dec_unit_vld = 1'b0;
    dec_unit     = 2'd0;
    case (ir_q[15:12])
      4'h0:             dec_nop = 1'b1;
      4'h1, 4'h2:       begin dec_unit_vld = 1'b1; dec_unit = 2'd0; end
      4'h3, 4'h4, 4'h5: begin dec_unit_vld = 1'b1; dec_unit = 2'd1; end
      4'h6:             begin dec_unit_vld = 1'b1; dec_unit = 2'd2; end
      4'h7:             begin dec_unit_vld = 1'b1; dec_unit = 2'd3; end
      4'hF:             dec_halt = 1'b1;
      default:          ;
    endcase
    // A unit index beyond the instantiated units is treated as illegal.
    unit_ok = dec_unit_vld && (int'(dec_unit) < int'(NUM_UNITS));
  end

  // Next-state logic; every output register is a function of the next state.
  always_comb begin
    state_d       = state_q;
    ir_d          = ir_q;
    sel_d         = sel_q;
    timer_d       = timer_q;
    illegal_d     = illegal_q;
    timeout_d     = timeout_q;
    instr_count_d = instr_count_q;

    case (state_q)
      StIdle: begin
        if (run_i) state_d = StFetch;
      end
      StFetch: begin
        if (mem_valid_i) begin
          ir_d    = mem_rdata_i;
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (dec_nop) begin
          state_d = StRetire;
        end else if (dec_halt) begin
          state_d = StHalted;
        end else if (unit_ok) begin
          sel_d   = SelW'(dec_unit);
          state_d = StDispatch;
        end else begin
          illegal_d = 1'b1;
          state_d   = StError;
        end
      end
      StDispatch: begin
        timer_d = '0;
        state_d = StWait;
      end
      StWait: begin
        if (unit_done_i[sel_q]) begin
          state_d = StRetire;
        end else if (timer_q == TimerW'(TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          state_d   = StError;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      StRetire: begin
        state_d = run_i ? StFetch : StIdle;
      end
      StHalted, StError: ;
      default: state_d = StIdle;
    endcase

    if (state_d == StRetire) instr_count_d = instr_count_q + 16'd1;

    unit_start_d = (state_d == StDispatch) ? (NUM_UNITS'(1) << sel_d) : '0;
    pc_inc_d     = (state_d == StRetire);
    busy_d       = !(state_d inside {StIdle, StHalted, StError});
    halted_d     = (state_d == StHalted);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      ir_q          <= '0;
      sel_q         <= '0;
      timer_q       <= '0;
      unit_start_q  <= '0;
      pc_inc_q      <= 1'b0;
      busy_q        <= 1'b0;
      halted_q      <= 1'b0;
      illegal_q     <= 1'b0;
      timeout_q     <= 1'b0;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      ir_q          <= ir_d;
      sel_q         <= sel_d;
      timer_q       <= timer_d;
      unit_start_q  <= unit_start_d;
      pc_inc_q      <= pc_inc_d;
      busy_q        <= busy_d;
      halted_q      <= halted_d;
      illegal_q     <= illegal_d;
      timeout_q     <= timeout_d;
      instr_count_q <= instr_count_d;
    end
  end

  assign ir_o          = ir_q;
  assign unit_start_o  = unit_start_q;
  assign pc_inc_o      = pc_inc_q;
  assign busy_o        = busy_q;
  assign halted_o      = halted_q;
  assign illegal_o     = illegal_q;
  assign timeout_err_o = timeout_q;
  assign instr_count_o = instr_count_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: expected starts/retires are queued when
// an instruction is presented and checked when the DUT pulses the strobe.
module tb_instr_sequencer;

  localparam int unsigned NumUnits = 4;
  localparam int unsigned Timeout  = 16;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                run = 1'b0;
  logic [15:0]         mem_rdata = '0;
  logic                mem_valid = 1'b0;
  logic [NumUnits-1:0] unit_done = '0;
  logic [15:0]         ir;
  logic [NumUnits-1:0] unit_start;
  logic                pc_inc, busy, halted, illegal, timeout_err;
  logic [15:0]         instr_count;

  instr_sequencer #(
    .NUM_UNITS(NumUnits),
    .TIMEOUT  (Timeout)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .run_i        (run),
    .mem_rdata_i  (mem_rdata),
    .mem_valid_i  (mem_valid),
    .unit_done_i  (unit_done),
    .ir_o         (ir),
    .unit_start_o (unit_start),
    .pc_inc_o     (pc_inc),
    .busy_o       (busy),
    .halted_o     (halted),
    .illegal_o    (illegal),
    .timeout_err_o(timeout_err),
    .instr_count_o(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] ir;
    logic [15:0] cnt;
  } ret_t;

  ret_t                ret_q[$];
  logic [NumUnits-1:0] start_q[$];
  int                  pc_cyc[$];
  int                  n_vec = 0;
  int                  n_err = 0;
  int                  cyc = 0;
  logic [15:0]         exp_cnt = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: pops expectations on each start/retire pulse.
  logic        prev_start = 1'b0, prev_pc = 1'b0, pend = 1'b0;
  logic [15:0] pend_cnt = '0;
  always @(negedge clk) begin
    if (rst) begin
      prev_start = 1'b0;
      prev_pc    = 1'b0;
      pend       = 1'b0;
    end else begin
      if (pend) begin
        check("retire_cnt", {16'd0, instr_count}, {16'd0, pend_cnt});
        pend = 1'b0;
      end
      if (unit_start != '0) begin
        if (prev_start) check("start_pulse", 32'(prev_start), 32'd0);
        if (start_q.size() == 0) check("start_unexp", 32'(unit_start), 32'd0);
        else check("start", 32'(unit_start), 32'(start_q.pop_front()));
      end
      if (pc_inc) begin
        pc_cyc.push_back(cyc);
        if (prev_pc) check("pc_pulse", 32'(prev_pc), 32'd0);
        if (ret_q.size() == 0) begin
          check("pc_unexp", 32'(pc_inc), 32'd0);
        end else begin
          ret_t r;
          r = ret_q.pop_front();
          check("retire_ir", {16'd0, ir}, {16'd0, r.ir});
          pend     = 1'b1;
          pend_cnt = r.cnt;
        end
      end
      prev_start = (unit_start != '0);
      prev_pc    = pc_inc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    run = 1'b0;
    mem_valid = 1'b0;
    unit_done = '0;
    ret_q.delete();
    start_q.delete();
    pc_cyc.delete();
    exp_cnt = '0;
    #2;
    rst = 1'b0;
  endtask

  task automatic push_retire(input logic [15:0] instr);
    ret_t r;
    exp_cnt = exp_cnt + 16'd1;
    r.ir  = instr;
    r.cnt = exp_cnt;
    ret_q.push_back(r);
  endtask

  // Present an instruction from IDLE; run optionally drops once FETCH is entered.
  task automatic issue(input logic [15:0] instr, input bit keep_run);
    mem_rdata = instr;
    mem_valid = 1'b1;
    run = 1'b1;
    tick();
    if (!keep_run) run = 1'b0;
  endtask

  task automatic wait_start();
    int n = 0;
    while (unit_start == '0 && n < 20) begin
      tick();
      n++;
    end
    if (unit_start == '0) check("start_seen", 32'd0, 32'd1);
  endtask

  // Run back-to-back NOPs and drop run during the last retire.
  task automatic run_nops(input int cnt);
    int seen = 0;
    int n = 0;
    for (int i = 0; i < cnt; i++) push_retire(16'h0000);
    mem_rdata = 16'h0000;
    mem_valid = 1'b1;
    run = 1'b1;
    while (seen < cnt && n < 20 * cnt) begin
      tick();
      n++;
      if (pc_inc) seen++;
    end
    run = 1'b0;
    if (seen < cnt) check("nop_retires", 32'(seen), 32'(cnt));
  endtask

  initial begin
    int n;
    #1 rst = 1'b1;
    #5;
    check("rst_ir", {16'd0, ir}, 32'd0);
    check("rst_start", 32'(unit_start), 32'd0);
    check("rst_flags", {27'd0, pc_inc, busy, halted, illegal, timeout_err}, 32'd0);
    check("rst_cnt", {16'd0, instr_count}, 32'd0);
    #2 rst = 1'b0;

    // Asynchronous reset in the middle of WAIT.
    tick();
    start_q.push_back(4'b0001);
    issue(16'h1045, 1'b0);
    wait_start();
    tick();
    tick();
    check("wait_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_ir", {16'd0, ir}, 32'd0);
    check("arst_flags", {27'd0, pc_inc, busy, halted, illegal, timeout_err}, 32'd0);
    check("arst_start", 32'(unit_start), 32'd0);
    do_reset();

    // Three NOPs: one retire every third cycle, no unit started.
    tick();
    run_nops(3);
    repeat (4) tick();
    check("nop_gap1", 32'(pc_cyc[1] - pc_cyc[0]), 32'd3);
    check("nop_gap2", 32'(pc_cyc[2] - pc_cyc[1]), 32'd3);
    check("nop_cnt", {16'd0, instr_count}, 32'd3);
    check("nop_idle", 32'(busy), 32'd0);

    // ALUI with a stray done from another unit during WAIT.
    start_q.push_back(4'b0001);
    push_retire(16'h1045);
    issue(16'h1045, 1'b0);
    wait_start();
    check("alui_ir", {16'd0, ir}, 32'h1045);
    tick();
    tick();
    unit_done = 4'b0100;
    tick();
    unit_done = '0;
    check("stray_ignored", {30'd0, busy, pc_inc}, 32'h2);
    tick();
    tick();
    unit_done = 4'b0001;
    tick();
    unit_done = '0;
    check("alui_pc_after_done", 32'(pc_inc), 32'd1);
    repeat (3) tick();
    check("alui_cnt", {16'd0, instr_count}, 32'd4);
    check("alui_idle", 32'(busy), 32'd0);

    // Unit1 never answers: timeout.
    start_q.push_back(4'b0010);
    issue(16'h3000, 1'b0);
    wait_start();
    n = 0;
    while (!timeout_err && n < 40) begin
      tick();
      n++;
    end
    check("tmo_cycles", 32'(n), 32'(Timeout + 1));
    check("tmo_state", {29'd0, busy, illegal, timeout_err}, 32'h1);
    repeat (3) tick();
    check("tmo_sticky", 32'(timeout_err), 32'd1);
    do_reset();

    // Illegal opcode: sticky ERROR.
    tick();
    issue(16'h9000, 1'b0);
    n = 0;
    while (!illegal && n < 10) begin
      tick();
      n++;
    end
    repeat (5) tick();
    check("ill_flags", {29'd0, busy, illegal, timeout_err}, 32'h2);
    check("ill_ir", {16'd0, ir}, 32'h9000);
    do_reset();

    // HALT with run held high: terminal, never retires.
    tick();
    issue(16'hF000, 1'b1);
    repeat (10) tick();
    check("halt_flags", {29'd0, busy, halted, pc_inc}, 32'h2);
    check("halt_cnt", {16'd0, instr_count}, 32'd0);
    run = 1'b0;
    do_reset();

    // Counter wrap from a preloaded value.
    tick();
    force dut.instr_count_q = 16'hFFFE;
    #1;
    release dut.instr_count_q;
    exp_cnt = 16'hFFFE;
    tick();
    run_nops(2);
    repeat (3) tick();
    check("wrap_cnt", {16'd0, instr_count}, 32'd0);

    // run dropped during WAIT: instruction still retires, then IDLE.
    start_q.push_back(4'b1000);
    push_retire(16'h7123);
    issue(16'h7123, 1'b1);
    wait_start();
    tick();
    run = 1'b0;
    tick();
    unit_done = 4'b1000;
    tick();
    unit_done = '0;
    check("run0_pc", 32'(pc_inc), 32'd1);
    repeat (6) tick();
    check("run0_idle", 32'(busy), 32'd0);
    check("run0_cnt", {16'd0, instr_count}, 32'd1);
    check("sb_empty", 32'(ret_q.size() + start_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
